dma_desc_sched: RTL

- Shares the single DMA pBuf descriptor path (pBufWR = receive buffers, pBufRD = transmit buffers) between NUM_REQ requesters (CPU cores / accelerators).
- Arbitrates round-robin, registers one descriptor per grant and issues it as a one-cycle write pulse into the pBufWR or pBufRD FIFO.
- Tracks free pBufWR slots with a credit counter. Sits between the per-core descriptor queues and the DMA engine's pBuf FIFOs.

---
 rtl/dma_sched_pkg.sv | 17 +
 rtl/dma_desc_sched_arb.sv | 71 +++++++
 rtl/dma_desc_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dma_sched_pkg.sv
// Shared types and widths for the DMA pBuf descriptor scheduler.
// States, descriptor field widths and FIFO word widths.
package dma_sched_pkg;

  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 16;
  localparam int TAG_W    = 4;
  localparam int PBUFWR_W = 48;
  localparam int PBUFRD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    ISSUE
  } state_t;

endpackage

// File: rtl/dma_desc_sched_arb.sv
// Round-robin pick over eligible requesters with a registered pointer.
// DMA_SCHED_PRIO_EN: requester 0 wins whenever eligible; pointer rotates over 1..N-1.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         elig,
  input  logic                       gnt_en,
  input  logic                       adv,
  input  logic [$clog2(NUM_REQ)-1:0] adv_id,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0] mask;
  logic               found;

  always_comb begin
    int j;
    j      = 0;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    mask   = elig;
`ifdef DMA_SCHED_PRIO_EN
    if (elig[0]) begin
      found  = 1'b1;
      gnt_id = '0;
    end
    mask[0] = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && mask[j]) begin
        found  = 1'b1;
        gnt_id = IW'(j);
      end
    end
    if (gnt_en && found) gnt[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_nxt = adv_id + IW'(1);
    if (adv_id == IW'(NUM_REQ - 1)) begin
`ifdef DMA_SCHED_PRIO_EN
      ptr_nxt = IW'(1);
`else
      ptr_nxt = '0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (adv) begin
`ifdef DMA_SCHED_PRIO_EN
      if (adv_id != '0) ptr <= ptr_nxt;
`else
      ptr <= ptr_nxt;
`endif
    end
  end

endmodule

// File: rtl/dma_desc_sched.sv
// Shares the DMA pBufWR/pBufRD descriptor path between NUM_REQ requesters.
// Optional strict priority for requester 0 via DMA_SCHED_PRIO_EN.
module dma_desc_sched
  import dma_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WR_DEPTH = 16,
  parameter int CW       = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ-1:0]        i_req_dir,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  i_req_len,
  output logic                      o_wren_pBufWR,
  output logic [PBUFWR_W-1:0]       o_din_pBufWR,
  output logic                      o_wren_pBufRD,
  output logic [PBUFRD_W-1:0]       o_din_pBufRD,
  input  logic                      i_wait_free_pBufWR,
  input  logic                      i_ret_pBufWR,
  output logic [CW-1:0]             o_credit_wr,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int PAD = PBUFRD_W - TAG_W - LEN_W - ADDR_W;

  state_t               state;
  state_t               state_nxt;
  logic                 grant_go;
  logic [NUM_REQ-1:0]   elig;
  logic                 wr_ok;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_id;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IW-1:0]        gid;
  logic                 dir_q;
  logic                 len_zero;
  logic [CW-1:0]        credit;
  logic                 ovf;
  logic [ADDR_W-1:0]    cap_addr;
  logic [LEN_W-1:0]     cap_len;
  logic                 cap_dir;

  assign wr_ok = (credit != '0) && !i_wait_free_pBufWR;
  assign elig  = i_req_valid & (i_req_dir | {NUM_REQ{wr_ok}});

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .elig    (elig),
    .gnt_en  (grant_go),
    .adv     (state == CAPTURE),
    .adv_id  (gid),
    .gnt     (arb_gnt),
    .gnt_id  (arb_id)
  );

  always_comb begin
    state_nxt = state;
    grant_go  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_en && (|elig)) begin
          state_nxt = CAPTURE;
          grant_go  = 1'b1;
        end
      end
      CAPTURE: state_nxt = ISSUE;
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cap_addr = i_req_addr[ADDR_W*gid +: ADDR_W];
  assign cap_len  = i_req_len[LEN_W*gid +: LEN_W];
  assign cap_dir  = i_req_dir[gid];

  assign o_req_ready   = (state == CAPTURE) ? gnt_q : '0;
  assign o_wren_pBufWR = (state == ISSUE) && !len_zero && !dir_q;
  assign o_wren_pBufRD = (state == ISSUE) && !len_zero && dir_q;
  assign o_busy        = (state != IDLE);
  assign o_credit_wr   = credit;

  // a return with every slot already free is a bookkeeping fault upstream
  assign ovf = i_ret_pBufWR && !o_wren_pBufWR && (credit == CW'(WR_DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      gnt_q        <= '0;
      gid          <= '0;
      dir_q        <= 1'b0;
      len_zero     <= 1'b0;
      o_din_pBufWR <= '0;
      o_din_pBufRD <= '0;
      credit       <= CW'(WR_DEPTH);
      o_err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_go) begin
        gnt_q <= arb_gnt;
        gid   <= arb_id;
      end
      if (state == CAPTURE) begin
        dir_q    <= cap_dir;
        len_zero <= (cap_len == '0);
        if (cap_len != '0) begin
          if (cap_dir) o_din_pBufRD <= {{PAD{1'b0}}, TAG_W'(gid), cap_len, cap_addr};
          else         o_din_pBufWR <= {cap_len, cap_addr};
        end
      end
      if (i_ret_pBufWR && !o_wren_pBufWR) begin
        if (credit != CW'(WR_DEPTH)) credit <= credit + CW'(1);
      end else if (o_wren_pBufWR && !i_ret_pBufWR) begin
        credit <= credit - CW'(1);
      end
      if (((state == ISSUE) && len_zero) || ovf) o_err <= 1'b1;
    end
  end

endmodule
